// File: rtl/dma_word_packer_pkg.sv
// Shared DMA definitions: FSM state encoding and default bus widths.
package dma_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 23;
    localparam int unsigned COUNT_WIDTH_DEF = 16;
    localparam int unsigned STATE_WIDTH     = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE  = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/dma_word_packer_if.sv
// FIFO read side and memory write port of the word packer.
interface dma_word_packer_if #(
    parameter int unsigned ADDR_WIDTH = dma_pkg::ADDR_WIDTH_DEF
);
    logic [7:0]            fifo_data;
    logic                  fifo_avail;
    logic                  fifo_pop;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_data;
    logic                  mem_ack;

    modport master (
        input  fifo_data, fifo_avail, mem_ack,
        output fifo_pop, mem_req, mem_addr, mem_data
    );

    modport slave (
        output fifo_data, fifo_avail, mem_ack,
        input  fifo_pop, mem_req, mem_addr, mem_data
    );
endinterface

// File: rtl/dma_word_packer.sv
// Pops FIFO bytes, packs big-endian 16-bit words and writes them to ST memory
// at an auto-incrementing word address for a programmed word count.
module dma_word_packer
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic                   abort,
    dma_word_packer_if.master      bus,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] words_left
);

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [15:0]            data_q;
    logic [COUNT_WIDTH-1:0] left_q;
    logic                   req_q;
    logic                   done_q;
    logic                   busy_q;
    logic                   pop_c;

    // Pop only when a byte is present; suppressed on cycles that reset or abort.
    assign pop_c = reset_n && !abort && bus.fifo_avail &&
                   ((state_q == ST_HI) || (state_q == ST_LO));

    assign bus.fifo_pop = pop_c;
    assign bus.mem_req  = req_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign words_left   = left_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            left_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (abort) begin
            // An abandoned write is cancelled by dropping the request.
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (word_count != '0) begin
                            addr_q  <= start_addr;
                            left_q  <= word_count;
                            state_q <= ST_HI;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_HI: begin
                    if (pop_c) begin
                        data_q[15:8] <= bus.fifo_data;
                        state_q      <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (pop_c) begin
                        data_q[7:0] <= bus.fifo_data;
                        req_q       <= 1'b1;
                        state_q     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_ack) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        left_q <= left_q - COUNT_WIDTH'(1);
                        req_q  <= 1'b0;
                        if (left_q == COUNT_WIDTH'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_HI;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_word_packer.sv
// Randomized scoreboard bench for dma_word_packer: FIFO and bus responders,
// a write monitor and a queue-based reference of expected memory writes.
module tb_dma_word_packer;
    import dma_pkg::*;

    localparam int unsigned AW = ADDR_WIDTH_DEF;
    localparam int unsigned CW = COUNT_WIDTH_DEF;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [CW-1:0] left;
    } wr_t;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] word_count;
    logic          abort;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_left;

    dma_word_packer_if #(.ADDR_WIDTH(AW)) bus ();

    dma_word_packer #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .words_left (words_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] fifo_q[$];
    wr_t        exp_q[$];
    int avail_pct = 100;
    int ack_delay = 0;
    bit ack_rand = 1'b0;
    bit spurious = 1'b0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int req_cnt = 0;
    int first_req_cyc = -1;
    int last_done_cyc = -1;
    int x_d0, x_p0, x_r0, x_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model: head byte visible while non-empty (optionally gated), popped after the edge.
    initial begin
        bit pend;
        pend = 1'b0;
        bus.fifo_avail = 1'b0;
        bus.fifo_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (fifo_q.size() > 0 && $urandom_range(99) < avail_pct) begin
                bus.fifo_avail = 1'b1;
                bus.fifo_data  = fifo_q[0];
            end else begin
                bus.fifo_avail = 1'b0;
                bus.fifo_data  = 8'($urandom);
            end
            #1;
            pend = bus.fifo_pop;
            if (bus.fifo_pop) begin
                pop_cnt++;
                chk("pop_needs_avail", 32'(bus.fifo_avail), 32'd1);
            end
        end
    end

    // Bus responder: ack after a programmed or random number of wait cycles.
    initial begin
        int waited;
        int target;
        waited = 0;
        target = 0;
        bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                if (waited == 0) target = ack_rand ? int'($urandom_range(3)) : ack_delay;
                if (waited >= target) begin
                    bus.mem_ack = 1'b1;
                    waited = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    waited++;
                end
            end else begin
                bus.mem_ack = spurious && ($urandom_range(3) == 0);
                waited = 0;
            end
        end
    end

    // Monitor: compares every completed write against the scoreboard.
    initial begin
        bit            prev_req;
        bit            prev_done;
        logic [AW-1:0] h_addr;
        logic [15:0]   h_data;
        wr_t           e;
        prev_req  = 1'b0;
        prev_done = 1'b0;
        h_addr    = '0;
        h_data    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n !== 1'b1) begin
                prev_req  = 1'b0;
                prev_done = 1'b0;
                continue;
            end
            if (bus.mem_req) begin
                req_cnt++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                chk("no_pop_in_write", 32'(bus.fifo_pop), 32'd0);
                if (prev_req) begin
                    chk("req_addr_stable", 32'(bus.mem_addr), 32'(h_addr));
                    chk("req_data_stable", 32'(bus.mem_data), 32'(h_data));
                end
                h_addr = bus.mem_addr;
                h_data = bus.mem_data;
                if (bus.mem_ack) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h, required none",
                                 bus.mem_addr, bus.mem_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                        chk("wr_data", 32'(bus.mem_data), 32'(e.data));
                        chk("wr_words_left", 32'(words_left), 32'(e.left));
                    end
                end
            end
            if (prev_done) chk("busy_after_done", 32'(busy), 32'd0);
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            prev_req  = bus.mem_req && !bus.mem_ack;
            prev_done = done;
        end
    end

    task automatic start_xfer(input logic [AW-1:0] addr, input int count,
                              input logic [7:0] bytes[$], input bit push_fifo, input bit push_exp);
        wr_t w;
        x_d0 = done_cnt;
        x_p0 = pop_cnt;
        x_r0 = req_cnt;
        first_req_cyc = -1;
        for (int i = 0; i < count; i++) begin
            w.addr = AW'((32'(addr) + i) % (2 ** AW));
            w.data = {bytes[2*i], bytes[2*i+1]};
            w.left = CW'(count - i);
            if (push_exp) exp_q.push_back(w);
            if (push_fifo) begin
                fifo_q.push_back(bytes[2*i]);
                fifo_q.push_back(bytes[2*i+1]);
            end
        end
        @(negedge clk);
        start      = 1'b1;
        start_addr = addr;
        word_count = CW'(count);
        x_s        = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, budget);
        end
    endtask

    task automatic finish_xfer(input string name, input int count, input bit timing);
        wait_idle(name, 4000);
        @(negedge clk);
        #3;
        chk({name, "_done_pulses"}, 32'(done_cnt - x_d0), 32'd1);
        chk({name, "_pops"}, 32'(pop_cnt - x_p0), 32'(2 * count));
        chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        if (timing) begin
            chk({name, "_done_cycle"}, 32'(last_done_cyc - x_s), 32'(3 * count + 1));
            if (count > 0) chk({name, "_first_req"}, 32'(first_req_cyc - x_s), 32'd3);
            else           chk({name, "_no_req"}, 32'(req_cnt - x_r0), 32'd0);
        end
        exp_q.delete();
    endtask

    function automatic void rand_bytes(input int count, output logic [7:0] b[$]);
        b = {};
        for (int i = 0; i < 2 * count; i++) b.push_back(8'($urandom));
    endfunction

    initial begin
        logic [7:0] bytes[$];
        int         n;
        int         cnt;
        logic [AW-1:0] a;

        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        start_addr = '0;
        word_count = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_pop", 32'(bus.fifo_pop), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_data", 32'(bus.mem_data), 32'd0);
        chk("rst_left", 32'(words_left), 32'd0);
        reset_n = 1'b1;

        // Basic transfer with immediate acks.
        bytes = {8'h12, 8'h34, 8'h56, 8'h78};
        start_xfer(23'h000100, 2, bytes, 1'b1, 1'b1);
        finish_xfer("basic", 2, 1'b1);

        // FIFO starvation: second byte arrives late.
        bytes = {8'hAB, 8'hCD};
        fifo_q.push_back(8'hAB);
        start_xfer(23'h000200, 1, bytes, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("starve_held_in_lo", 32'(pop_cnt - x_p0), 32'd1);
        fifo_q.push_back(8'hCD);
        finish_xfer("starve", 1, 1'b0);

        // Bus backpressure: five request cycles per word.
        ack_delay = 4;
        rand_bytes(2, bytes);
        start_xfer(23'h012345, 2, bytes, 1'b1, 1'b1);
        finish_xfer("backpressure", 2, 1'b0);
        chk("backpressure_req_cycles", 32'(req_cnt - x_r0), 32'd10);
        ack_delay = 0;

        // Address wrap and zero count.
        rand_bytes(2, bytes);
        start_xfer(23'h7FFFFF, 2, bytes, 1'b1, 1'b1);
        finish_xfer("wrap", 2, 1'b1);
        bytes = {};
        start_xfer(23'h000400, 0, bytes, 1'b1, 1'b1);
        finish_xfer("zero", 0, 1'b1);

        // Abort while a write is pending.
        ack_delay = 20;
        rand_bytes(3, bytes);
        start_xfer(23'h000500, 3, bytes, 1'b1, 1'b0);
        n = 0;
        while (!bus.mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_write", 32'(bus.mem_req), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_req_drop", 32'(bus.mem_req), 32'd0);
        chk("abort_busy_drop", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #3;
        chk("abort_no_done", 32'(done_cnt - x_d0), 32'd0);
        chk("abort_pops", 32'(pop_cnt - x_p0), 32'd2);
        fifo_q.delete();
        ack_delay = 0;
        repeat (2) @(negedge clk);
        rand_bytes(2, bytes);
        start_xfer(23'h000600, 2, bytes, 1'b1, 1'b1);
        finish_xfer("after_abort", 2, 1'b1);

        // Reset while waiting in LO; a same-cycle start must be ignored.
        bytes = {8'h11, 8'h22, 8'h33, 8'h44};
        fifo_q.push_back(8'h11);
        start_xfer(23'h000700, 2, bytes, 1'b0, 1'b0);
        n = 0;
        while (pop_cnt == x_p0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("midrst_in_lo", 32'(busy), 32'd1);
        reset_n    = 1'b0;
        start      = 1'b1;
        start_addr = 23'h000005;
        word_count = CW'(3);
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req", 32'(bus.mem_req), 32'd0);
        chk("midrst_addr", 32'(bus.mem_addr), 32'd0);
        chk("midrst_data", 32'(bus.mem_data), 32'd0);
        chk("midrst_left", 32'(words_left), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        #1;
        chk("midrst_start_ignored", 32'(busy), 32'd0);
        fifo_q.delete();

        // Randomized transfers with FIFO gaps, random ack latency and stray acks.
        spurious = 1'b1;
        ack_rand = 1'b1;
        for (int t = 0; t < 12; t++) begin
            avail_pct = int'($urandom_range(100, 40));
            cnt = int'($urandom_range(6, 1));
            a = (t % 4 == 3) ? 23'h7FFFFD : AW'($urandom);
            rand_bytes(cnt, bytes);
            start_xfer(a, cnt, bytes, 1'b1, 1'b1);
            finish_xfer("random", cnt, 1'b0);
            fifo_q.delete();
        end
        spurious = 1'b0;
        ack_rand = 1'b0;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_word_packer.md
# dma_word_packer

Downstream consumer of the Atari ST IO-controller byte FIFO.
- Pops bytes from the FIFO read side.
- Assembles big-endian 16-bit words.
- Writes each word to ST memory through a request/acknowledge bus port, at an auto-incrementing word address, for a programmed word count.
- Sits between the FIFO output and the ST bus arbiter on the DMA read-from-device path (device → RAM).

## Interface
Parameters:
- ADDR_WIDTH, 23: word-address width (24-bit byte address, bit 0 dropped).
- COUNT_WIDTH, 16: word-count width.

Ports:
- clk  in  1  single clock; FIFO read side and bus port run on it.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; loads start_addr/word_count when idle.
- start_addr  in  ADDR_WIDTH  first word address.
- word_count  in  COUNT_WIDTH  words to transfer.
- abort  in  1  cancels the transfer immediately.
- fifo_data  in  8  FIFO head byte, combinational.
- fifo_avail  in  1  FIFO non-empty.
- fifo_pop  out  1  one-cycle pop; wired to the FIFO read enable.
- mem_req  out  1  write request, held until acked.
- mem_addr  out  ADDR_WIDTH  word address of the current write.
- mem_data  out  16  {high byte, low byte}.
- mem_ack  in  1  one-cycle acknowledge; the write completes on that edge.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on normal completion; not raised on abort.
- words_left  out  COUNT_WIDTH  remaining word count.

## Operation
States: IDLE, HI, LO, WRITE, DONE.
- IDLE
  - start with word_count≠0 → load address and count, go to HI.
  - start with word_count=0 → go straight to DONE.
- HI
  - If fifo_avail: latch fifo_data as the high byte, assert fifo_pop, go to LO.
  - Otherwise wait.
- LO
  - If fifo_avail: latch the low byte, assert fifo_pop, go to WRITE.
- WRITE
  - mem_req=1, with mem_addr and mem_data stable.
  - On mem_ack: address+1 (wraps modulo 2^ADDR_WIDTH) and words_left−1.
  - Then go to DONE if words_left was 1, else to HI.
- DONE: done=1 for one cycle, then IDLE.

Rules:
- fifo_pop is never asserted unless fifo_avail is high in the same cycle.
- fifo_pop is at most one cycle per byte.
- start is ignored while busy.
- abort has priority over everything, in any state: go to IDLE on the next edge and drop mem_req.
  - A write abandoned mid-request is not completed; the arbiter treats the request drop as a cancel.
  - Latched bytes are discarded. Bytes already popped are lost.
- mem_ack outside WRITE is ignored.
- The byte order is fixed: the first FIFO byte is mem_data[15:8].

## Timing
- Reset (reset_n low at an edge):
  - State is IDLE.
  - fifo_pop=0, mem_req=0, done=0, busy=0.
  - mem_addr=0, mem_data=0, words_left=0.
- mem_addr and mem_data are registered. They change only on load, on the HI/LO latch, and on ack.
- fifo_pop is combinational from the state and fifo_avail. The FIFO pointer advances on the same edge, and the next byte is visible on the following cycle.
- Best-case throughput, with the FIFO always non-empty and mem_ack returned on the first req cycle: 3 cycles per word (HI, LO, WRITE).
- Latency from start to first mem_req: 3 cycles minimum (load edge, HI, LO; mem_req asserted in the next cycle).
- The final ack edge enters DONE. done is high in the cycle after that edge. busy falls one cycle later.
- If the FIFO empties between HI and LO, the block waits in LO while holding the high byte. No timeout.

## Structure
- The shared package `dma_pkg` holds:
  - state encoding localparams (IDLE=0, HI=1, LO=2, WRITE=3, DONE=4; 3 bits);
  - default ADDR_WIDTH/COUNT_WIDTH constants, shared with the bus arbiter.
- Single flat module with no sub-modules. The address counter and word counter are inline registers.

## Test plan
- **Basic transfer:** start_addr=0x000100, word_count=2; FIFO bytes 0x12,0x34,0x56,0x78; ack on the first req cycle.
  - Writes 0x1234@0x000100, then 0x5678@0x000101.
  - done pulse; 4 pops total.
  - 3 cycles per word.
- **FIFO starvation:** word_count=1; byte 0x AB arrives, then 5 empty cycles, then 0xCD.
  - fifo_pop is never high while fifo_avail is low.
  - Single write 0xABCD.
- **Bus backpressure:** mem_ack delayed 4 cycles.
  - mem_req, mem_addr and mem_data stay stable for all 5 req cycles.
  - No pops occur during WRITE.
- **Wrap and zero count:**
  - start_addr=0x7FFFFF, word_count=2 → writes at 0x7FFFFF, then 0x000000.
  - word_count=0 → done 1 cycle after start, no pop, no req.
- **Abort during WRITE:** assert abort while mem_req=1.
  - mem_req=0 and busy=0 on the next cycle; no done pulse.
  - A subsequent start runs normally.
- **Reset mid-transfer:** reset_n low during LO.
  - All outputs return to reset values on the next edge.
  - start received in the same cycle is ignored.
